ram_rr_arb: RTL
===============

RAM_RR_ARB -- requirements
Module: ram_rr_arb

Interface
REQ-001 Parameter WIDTH, default 10, word-address width of every port.
REQ-002 Parameter TIMEOUT, default 15, the number of BUSY cycles without x_ack before the cycle is aborted; legal range 1..255.
REQ-003 wb_clk  input  1  single clock; all state updates on rising edge.
REQ-004 wb_rst  input  1  asynchronous, active-high reset.
REQ-005 r_cyc  input  4  per-requester cycle request, bit i = requester i.
REQ-006 r_we  input  4  per-requester write enable.
REQ-007 r_sel  input  16  byte selects, requester i in [4i+3:4i].
REQ-008 r_adr  input  4*WIDTH  addresses, requester i in [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-009 r_dat  input  128  write data, requester i in [32i+31:32i].
REQ-010 r_ack  output  4  per-requester acknowledge.
REQ-011 r_err  output  4  per-requester timeout error.
REQ-012 r_rdt  output  32  read data, shared by all requesters, valid only with an r_ack bit of a read.
REQ-013 x_cyc, x_we, x_sel[3:0], x_adr[WIDTH-1:0], x_dat[31:0]  output  the single RAM-side Wishbone port.
REQ-014 x_ack, x_rdt[31:0]  input  RAM-side acknowledge and read data.

Function
REQ-015 FSM states IDLE and BUSY; the FSM holds registered grant index g (2 bits), rotate pointer ptr (2 bits) and timeout counter cnt (8 bits).
REQ-016 In IDLE with any r_cyc high, the arbiter picks the first set bit scanning ptr, ptr+1, ... mod 4; next edge: g <= pick, state <= BUSY, cnt <= 0.
REQ-017 Arbitration latency is exactly one cycle: x_cyc is low in IDLE and is first asserted in the cycle after the request is sampled.
REQ-018 In BUSY: x_cyc = r_cyc[g] and cnt != TIMEOUT; x_we/x_sel/x_adr/x_dat are the fields of requester g.
REQ-019 x_we, x_sel, x_adr and x_dat are 0 whenever x_cyc is low.
REQ-020 x_dat is 0 unless x_we is high.
REQ-021 r_ack[g] = BUSY & x_ack & r_cyc[g], combinational; all other r_ack bits are 0.
REQ-022 r_rdt = x_rdt when r_ack[g] & !r_we[g], else 0.
REQ-023 On r_ack[g]: next state IDLE and ptr <= g+1 (mod 4) — rotating priority, so any requester waits at most 3 foreign transactions.
REQ-024 In BUSY, if r_cyc[g] drops without ack (abandon): next state IDLE, ptr unchanged.
REQ-025 In BUSY without ack, cnt increments each cycle.
REQ-026 When cnt == TIMEOUT in BUSY: r_err[g] = 1 for that single cycle, x_cyc = 0, r_ack all 0, next state IDLE, ptr <= g+1.
REQ-027 r_err is 0 at all other times.
REQ-028 An x_ack arriving when x_cyc is low is ignored.
REQ-029 One IDLE cycle always separates consecutive grants.
REQ-030 Simultaneous requests are resolved solely by ptr.
REQ-031 A requester whose r_cyc falls while in IDLE is never granted.

Reset
REQ-032 While wb_rst is high: state = IDLE, g = 0, ptr = 0, cnt = 0.
REQ-033 While wb_rst is high, all outputs are 0: x_cyc, x_we, x_sel, x_adr, x_dat, r_ack, r_err, r_rdt.
REQ-034 Reset asserted mid-transaction aborts it immediately (asynchronously) with no ack or err; after release the FSM starts from IDLE with ptr = 0.

Structure
REQ-035 Port count (4), state encodings and the TIMEOUT maximum live in the shared ram_arb_pkg constants header.
REQ-036 The rotating-priority pick is a sub-module rr_pick (inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0]), purely combinational.

Verification
REQ-037 Reset, then r_cyc=4'b0001 read at adr 5, x_ack on 2nd BUSY cycle with x_rdt=32'hDEADBEEF -> x_cyc rises 1 cycle after request; r_ack[0] and r_rdt=DEADBEEF in the same cycle as x_ack; ptr=1.
REQ-038 r_cyc=4'b1111 held, RAM acks every 1st BUSY cycle -> grant order 0,1,2,3,0 with an IDLE gap between grants.
REQ-039 Requester 2 writes r_dat=32'h12345678 with sel=4'b0011 -> x_dat=12345678, x_sel=0011, x_we=1; r_rdt stays 0 throughout.
REQ-040 TIMEOUT=3, x_ack never asserted -> r_err[g] pulses once on the 4th BUSY cycle, x_cyc low that cycle, FSM in IDLE next cycle, ptr advanced.
REQ-041 wb_rst pulsed asynchronously mid-BUSY -> all outputs drop before the next clock edge; first post-reset grant goes to the lowest requesting index.
REQ-042 Requester 1 drops r_cyc after 2 BUSY cycles without ack -> no ack or err, FSM in IDLE, ptr unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the four-port round-robin RAM arbiter.
package ram_arb_pkg;

    localparam int NUM_PORTS   = 4;
    localparam int TIMEOUT_MAX = 255;
    localparam int CNT_W       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_rr_arb_pick.sv
// Rotating-priority pick: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic                 valid,
    output logic [1:0]           idx
);

    logic [1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_cand = ptr + 2'(k);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/ram_rr_arb.sv
// Four requesters share one Wishbone RAM port through a rotating-priority arbiter
// with a per-transaction acknowledge timeout.
module ram_rr_arb
    import ram_arb_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [3:0]           r_cyc,
    input  logic [3:0]           r_we,
    input  logic [15:0]          r_sel,
    input  logic [4*WIDTH-1:0]   r_adr,
    input  logic [127:0]         r_dat,
    output logic [3:0]           r_ack,
    output logic [3:0]           r_err,
    output logic [31:0]          r_rdt,
    output logic                 x_cyc,
    output logic                 x_we,
    output logic [3:0]           x_sel,
    output logic [WIDTH-1:0]     x_adr,
    output logic [31:0]          x_dat,
    input  logic                 x_ack,
    input  logic [31:0]          x_rdt
);

    localparam int TMO_CLAMP = (TIMEOUT > TIMEOUT_MAX) ? TIMEOUT_MAX : TIMEOUT;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TMO_CLAMP);

    state_t           r_state;
    logic [1:0]       r_g;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_busy;
    logic       w_live;
    logic       w_expired;
    logic       w_xcyc;
    logic       w_ack;
    logic       w_we;

    rr_pick u_pick (
        .req   (r_cyc),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_busy    = (r_state == ST_BUSY);
    assign w_live    = r_cyc[r_g];
    assign w_expired = w_busy && (r_cnt == TMO);
    assign w_xcyc    = w_busy && w_live && !w_expired;
    assign w_ack     = w_xcyc && x_ack;
    assign w_we      = w_xcyc && r_we[r_g];

    // Only the granted requester's fields reach the RAM; everything else is forced to zero.
    assign x_cyc = w_xcyc;
    assign x_we  = w_we;
    assign x_sel = w_xcyc ? r_sel[4*r_g +: 4]         : 4'b0;
    assign x_adr = w_xcyc ? r_adr[WIDTH*r_g +: WIDTH] : '0;
    assign x_dat = w_we   ? r_dat[32*r_g +: 32]       : 32'b0;

    assign r_ack = w_ack     ? (4'b0001 << r_g) : 4'b0;
    assign r_err = w_expired ? (4'b0001 << r_g) : 4'b0;
    assign r_rdt = (w_ack && !r_we[r_g]) ? x_rdt : 32'b0;

    // Completion or timeout rotates priority past the granted port; abandonment leaves it alone.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= ST_IDLE;
            r_g     <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_g     <= w_pick_idx;
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (w_expired) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_g + 2'd1;
                    end else if (!w_live) begin
                        r_state <= ST_IDLE;
                    end else if (x_ack) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_g + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
